// File: rtl/irq_sequencer_if.sv
// Signal bundle between the control FSM (master) and the interrupt sequencer (slave).
interface irq_sequencer_if;
  logic       nmi_n;
  logic       irq_n;
  logic       p_i;
  logic       last_cycle;
  logic       brk_op;
  logic       vec_lo_rd;
  logic       seq_done;
  logic       force_brk;
  logic [7:0] vector_lo;
  logic       b_flag;
  logic       set_i;
  logic       int_active;
  logic       nmi_pending;

  modport master (
    output nmi_n, irq_n, p_i, last_cycle, brk_op, vec_lo_rd, seq_done,
    input  force_brk, vector_lo, b_flag, set_i, int_active, nmi_pending
  );

  modport slave (
    input  nmi_n, irq_n, p_i, last_cycle, brk_op, vec_lo_rd, seq_done,
    output force_brk, vector_lo, b_flag, set_i, int_active, nmi_pending
  );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt front-end for the 6502 control FSM: NMI/IRQ/BRK/reset sequencing,
// opcode forcing at instruction boundaries and vector low-byte selection.
module irq_sequencer #(
  parameter logic [7:0] NMI_VEC = 8'hFA,
  parameter logic [7:0] RST_VEC = 8'hFC,
  parameter logic [7:0] IRQ_VEC = 8'hFE
) (
  input  logic            ph1,
  input  logic            reset,
  irq_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FORCE, S_SERVICE, S_RST} state_t;
  typedef enum logic [1:0] {K_RST, K_NMI, K_IRQ, K_BRK} kind_t;

  state_t r_state, w_state_nxt;
  kind_t  r_kind,  w_kind_nxt;
  logic   r_nmi_pend, r_nmi_prev, r_set_i;
  logic   w_irq_req, w_nmi_edge, w_nmi_clr, w_done;

  assign w_irq_req  = ~bus.irq_n & ~bus.p_i;
  assign w_nmi_edge = r_nmi_prev & ~bus.nmi_n;

  always_ff @(posedge ph1) begin
    if (!reset) begin
      r_state    <= S_RST;
      r_kind     <= K_RST;
      r_nmi_pend <= 1'b0;
      r_nmi_prev <= 1'b1;
      r_set_i    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_kind     <= w_kind_nxt;
      r_nmi_prev <= bus.nmi_n;
      // a fresh edge wins over a same-cycle acceptance
      r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);
      r_set_i    <= w_done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = r_kind;
    w_nmi_clr   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.last_cycle && r_nmi_pend) begin
          w_state_nxt = S_FORCE;
          w_kind_nxt  = K_NMI;
          w_nmi_clr   = 1'b1;
        end else if (bus.last_cycle && w_irq_req) begin
          w_state_nxt = S_FORCE;
          w_kind_nxt  = K_IRQ;
        end else if (bus.brk_op) begin
          w_state_nxt = S_SERVICE;
          w_kind_nxt  = K_BRK;
        end
      end
      S_FORCE: w_state_nxt = S_SERVICE;
      S_SERVICE: begin
        // pending NMI steals an IRQ/BRK sequence before the vector is consumed
        if (bus.vec_lo_rd && r_nmi_pend && (r_kind == K_IRQ || r_kind == K_BRK)) begin
          w_kind_nxt = K_NMI;
          w_nmi_clr  = 1'b1;
        end
        if (bus.seq_done) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      S_RST: begin
        if (bus.seq_done) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_RST;
    endcase
  end

  always_comb begin
    bus.force_brk   = (r_state == S_FORCE);
    bus.b_flag      = (r_state == S_SERVICE) && (r_kind == K_BRK);
    bus.set_i       = r_set_i;
    bus.int_active  = (r_state != S_IDLE);
    bus.nmi_pending = r_nmi_pend;
    case (r_kind)
      K_RST:   bus.vector_lo = RST_VEC;
      K_NMI:   bus.vector_lo = NMI_VEC;
      default: bus.vector_lo = IRQ_VEC;
    endcase
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: vector table plus hand-written corner sequences.
module tb_irq_sequencer;

  typedef struct packed {
    logic rst_n, nmi_n, irq_n, p_i, lc, brk, vrd, done;
  } in_t;

  typedef struct packed {
    logic       fb;
    logic [7:0] vl;
    logic       bf, si, ia, np;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic ph1 = 1'b0;
  logic reset;
  irq_sequencer_if bus ();

  irq_sequencer #(.NMI_VEC(8'hFA), .RST_VEC(8'hFC), .IRQ_VEC(8'hFE)) dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ph1 = ~ph1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  function automatic in_t I(logic rst_n, logic nmi_n, logic irq_n, logic p_i,
                            logic lc, logic brk, logic vrd, logic done);
    return '{rst_n, nmi_n, irq_n, p_i, lc, brk, vrd, done};
  endfunction

  function automatic exp_t E(logic fb, logic [7:0] vl, logic bf, logic si,
                             logic ia, logic np);
    return '{fb, vl, bf, si, ia, np};
  endfunction

  task automatic drive(input in_t i);
    reset          = i.rst_n;
    bus.nmi_n      = i.nmi_n;
    bus.irq_n      = i.irq_n;
    bus.p_i        = i.p_i;
    bus.last_cycle = i.lc;
    bus.brk_op     = i.brk;
    bus.vec_lo_rd  = i.vrd;
    bus.seq_done   = i.done;
  endtask

  // drive, push expectation, clock, pop and compare
  task automatic step(input string name, input in_t i, input exp_t e);
    exp_t want, got;
    drive(i);
    sb_q.push_back(e);
    @(posedge ph1);
    #1;
    want = sb_q.pop_front();
    got  = '{bus.force_brk, bus.vector_lo, bus.b_flag, bus.set_i,
             bus.int_active, bus.nmi_pending};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got fb=%b vl=%h bf=%b si=%b ia=%b np=%b, want fb=%b vl=%h bf=%b si=%b ia=%b np=%b",
               name, got.fb, got.vl, got.bf, got.si, got.ia, got.np,
               want.fb, want.vl, want.bf, want.si, want.ia, want.np);
    end
  endtask

  vec_t tbl[12];

  initial begin
    drive(I(0,1,1,0,0,0,0,0));
    #1;

    // reset, IRQ taken, IRQ masked, seq_done ignored in IDLE
    tbl[0]  = '{I(0,1,1,0,0,0,0,0), E(0,8'hFC,0,0,1,0)};
    tbl[1]  = '{I(0,1,1,0,0,0,0,0), E(0,8'hFC,0,0,1,0)};
    tbl[2]  = '{I(1,1,1,0,0,0,0,0), E(0,8'hFC,0,0,1,0)};
    tbl[3]  = '{I(1,1,1,0,0,0,0,1), E(0,8'hFC,0,1,0,0)};
    tbl[4]  = '{I(1,1,1,0,0,0,0,0), E(0,8'hFC,0,0,0,0)};
    tbl[5]  = '{I(1,1,0,0,1,0,0,0), E(1,8'hFE,0,0,1,0)};
    tbl[6]  = '{I(1,1,0,0,0,0,0,0), E(0,8'hFE,0,0,1,0)};
    tbl[7]  = '{I(1,1,0,0,0,0,1,0), E(0,8'hFE,0,0,1,0)};
    tbl[8]  = '{I(1,1,1,0,0,0,0,1), E(0,8'hFE,0,1,0,0)};
    tbl[9]  = '{I(1,1,0,1,1,0,0,0), E(0,8'hFE,0,0,0,0)};
    tbl[10] = '{I(1,1,0,1,1,0,0,0), E(0,8'hFE,0,0,0,0)};
    tbl[11] = '{I(1,1,1,0,0,0,0,1), E(0,8'hFE,0,0,0,0)};
    for (int k = 0; k < 12; k++) step($sformatf("tbl%0d", k), tbl[k].i, tbl[k].e);

    // NMI held low across boundaries: one acceptance, re-arm only on a new edge
    step("nmi_latch",   I(1,0,1,0,0,0,0,0), E(0,8'hFE,0,0,0,1));
    step("nmi_force",   I(1,0,1,0,1,0,0,0), E(1,8'hFA,0,0,1,0));
    step("nmi_svc",     I(1,0,1,0,0,0,0,0), E(0,8'hFA,0,0,1,0));
    step("nmi_done",    I(1,0,1,0,0,0,0,1), E(0,8'hFA,0,1,0,0));
    step("nmi_held1",   I(1,0,1,0,1,0,0,0), E(0,8'hFA,0,0,0,0));
    step("nmi_held2",   I(1,0,1,0,1,0,0,0), E(0,8'hFA,0,0,0,0));
    step("nmi_rise",    I(1,1,1,0,0,0,0,0), E(0,8'hFA,0,0,0,0));
    step("nmi_refall",  I(1,0,1,0,0,0,0,0), E(0,8'hFA,0,0,0,1));
    step("nmi2_force",  I(1,0,1,0,1,0,0,0), E(1,8'hFA,0,0,1,0));
    step("nmi2_svc",    I(1,0,1,0,0,0,0,0), E(0,8'hFA,0,0,1,0));
    step("nmi2_done",   I(1,0,1,0,0,0,0,1), E(0,8'hFA,0,1,0,0));

    // NMI and IRQ pending at the same boundary: NMI first, then IRQ
    step("pri_rise",    I(1,1,1,0,0,0,0,0), E(0,8'hFA,0,0,0,0));
    step("pri_both",    I(1,0,0,0,0,0,0,0), E(0,8'hFA,0,0,0,1));
    step("pri_nmi",     I(1,0,0,0,1,0,0,0), E(1,8'hFA,0,0,1,0));
    step("pri_svc",     I(1,0,0,1,0,0,0,0), E(0,8'hFA,0,0,1,0));
    step("pri_done",    I(1,0,0,1,0,0,0,1), E(0,8'hFA,0,1,0,0));
    step("pri_irq",     I(1,0,0,0,1,0,0,0), E(1,8'hFE,0,0,1,0));
    step("pri_irqsvc",  I(1,0,1,0,0,0,0,0), E(0,8'hFE,0,0,1,0));
    step("pri_irqdone", I(1,0,1,0,0,0,0,1), E(0,8'hFE,0,1,0,0));

    // software BRK hijacked by NMI at the vector read
    step("hj_rise",     I(1,1,1,0,0,0,0,0), E(0,8'hFE,0,0,0,0));
    step("hj_brk",      I(1,1,1,0,0,1,0,0), E(0,8'hFE,1,0,1,0));
    step("hj_edge",     I(1,0,1,0,0,0,0,0), E(0,8'hFE,1,0,1,1));
    step("hj_vrd",      I(1,0,1,0,0,0,1,0), E(0,8'hFA,0,0,1,0));
    step("hj_done",     I(1,0,1,0,0,0,0,1), E(0,8'hFA,0,1,0,0));
    step("hj_no2nd",    I(1,0,1,0,1,0,0,0), E(0,8'hFA,0,0,0,0));

    // reset in mid-SERVICE with an NMI pending; NMI latches but waits in RST_SEQ
    step("mr_rise",     I(1,1,1,0,0,0,0,0), E(0,8'hFA,0,0,0,0));
    step("mr_irq",      I(1,1,0,0,1,0,0,0), E(1,8'hFE,0,0,1,0));
    step("mr_edge",     I(1,0,1,0,0,0,0,0), E(0,8'hFE,0,0,1,1));
    step("mr_reset",    I(0,0,1,0,0,0,0,0), E(0,8'hFC,0,0,1,0));
    step("mr_release",  I(1,1,1,0,0,0,0,0), E(0,8'hFC,0,0,1,0));
    step("mr_rstedge",  I(1,0,1,0,0,0,0,0), E(0,8'hFC,0,0,1,1));
    step("mr_notake",   I(1,0,1,0,1,0,0,0), E(0,8'hFC,0,0,1,1));
    step("mr_done",     I(1,0,1,0,0,0,0,1), E(0,8'hFC,0,1,0,1));
    step("mr_nmi",      I(1,0,1,0,1,0,0,0), E(1,8'hFA,0,0,1,0));
    step("mr_svc",      I(1,0,1,0,0,0,0,0), E(0,8'hFA,0,0,1,0));
    step("mr_svcdone",  I(1,0,1,0,0,0,0,1), E(0,8'hFA,0,1,0,0));

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
